// File: rtl/uart_cmd_parser.sv
// 8N1 UART receiver feeding a 4-byte command frame parser (HDR, cmd, arg, checksum).
// Emits a one-cycle cmd_valid on a good frame and frame_err on checksum/timeout/stop errors.
module uart_cmd_parser #(
    parameter int unsigned CLK_FREQ     = 24000000,
    parameter int unsigned BAUD         = 9600,
    parameter logic [7:0]  HDR          = 8'hAA,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_data,
    output logic       cmd_valid,
    output logic [7:0] cmd,
    output logic [7:0] arg,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_DIV  = BAUD_DIV / 2;
    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int unsigned CW        = $clog2(BAUD_DIV + 1);
    localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;
    typedef enum logic [1:0] {PIdle, PCmd, PArg, PChk} p_state_e;

    // ---------------- synchronizer ----------------
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_data;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // ---------------- receiver ----------------
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            stop_err_q, stop_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= RxIdle;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        baud_cnt_d   = baud_cnt_q + CW'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                baud_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RxStart;
            end
            RxStart: begin
                // Mid-start-bit check rejects short low glitches.
                if (baud_cnt_q == CW'(HALF_DIV - 1)) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (baud_cnt_q == CW'(BAUD_DIV - 1)) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s2_q, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (baud_cnt_q == CW'(BAUD_DIV - 1)) begin
                    baud_cnt_d = '0;
                    if (rx_s2_q) begin
                        byte_valid_d = 1'b1;
                        rx_state_d   = RxIdle;
                    end else begin
                        stop_err_d = 1'b1;
                        rx_state_d = RxBreak;
                    end
                end
            end
            RxBreak: begin
                baud_cnt_d = '0;
                if (rx_s2_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------- frame parser ----------------
    p_state_e       p_state_q, p_state_d;
    logic [7:0]     cmd_tmp_q, cmd_tmp_d, arg_tmp_q, arg_tmp_d;
    logic [7:0]     cmd_q, cmd_d, arg_q, arg_d;
    logic           cmd_valid_q, cmd_valid_d, frame_err_q, frame_err_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]     chk_sum;
    logic           tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q   <= PIdle;
            cmd_tmp_q   <= '0;
            arg_tmp_q   <= '0;
            cmd_q       <= '0;
            arg_q       <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            p_state_q   <= p_state_d;
            cmd_tmp_q   <= cmd_tmp_d;
            arg_tmp_q   <= arg_tmp_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign chk_sum = cmd_tmp_q + arg_tmp_q;
    // frame_err is registered, so firing at LIMIT-2 lands it TMO_LIMIT cycles after byte_valid.
    assign tmo_hit = (p_state_q != PIdle) && (tmo_cnt_q == TW'(TMO_LIMIT - 2));

    always_comb begin
        p_state_d   = p_state_q;
        cmd_tmp_d   = cmd_tmp_q;
        arg_tmp_d   = arg_tmp_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        tmo_cnt_d   = (p_state_q == PIdle || byte_valid_q) ? '0 : tmo_cnt_q + TW'(1);
        if (byte_valid_q) begin
            unique case (p_state_q)
                PIdle: if (shift_q == HDR) p_state_d = PCmd;
                PCmd: begin
                    cmd_tmp_d = shift_q;
                    p_state_d = PArg;
                end
                PArg: begin
                    arg_tmp_d = shift_q;
                    p_state_d = PChk;
                end
                PChk: begin
                    if (shift_q == chk_sum) begin
                        cmd_d       = cmd_tmp_q;
                        arg_d       = arg_tmp_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    p_state_d = PIdle;
                end
                default: p_state_d = PIdle;
            endcase
        end else if ((stop_err_q && p_state_q != PIdle) || tmo_hit) begin
            frame_err_d = 1'b1;
            p_state_d   = PIdle;
        end
        err_cnt_d = (frame_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign arg       = arg_q;
    assign frame_err = frame_err_q;
    assign busy      = (p_state_q != PIdle);
    assign err_cnt   = err_cnt_q;

endmodule
